div_32_arbiter: RTL and testbench

Round-robin scheduler that shares one `div_32` unsigned divider between `P_NUM_REQ` requesters in the pi-calculation datapath. Each requester presents a dividend/divisor pair with a valid/ready handshake. The arbiter grants one requester at a time, sequences the divider's `start`/`done` protocol, and returns quotient and remainder to the granted requester as a one-cycle response. Divide-by-zero and a hung divider are handled locally, without stalling other requesters.

---
 rtl/div_32_arbiter.sv | 171 +++++++++++++++++
 tb/tb_div_32_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_32_arbiter.sv
// Round-robin arbiter sharing one unsigned divider between several requesters.
// Handles divide-by-zero locally and aborts a divider that never completes.
module div_32_arbiter #(
    parameter int P_WIDTH   = 32,
    parameter int P_NUM_REQ = 4,
    parameter int P_TIMEOUT = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [P_NUM_REQ-1:0]           req_valid,
    output logic [P_NUM_REQ-1:0]           req_ready,
    input  logic [P_NUM_REQ*P_WIDTH-1:0]   req_dividend,
    input  logic [P_NUM_REQ*P_WIDTH-1:0]   req_divisor,
    output logic [P_NUM_REQ-1:0]           rsp_valid,
    output logic [P_WIDTH-1:0]             rsp_quotient,
    output logic [P_WIDTH-1:0]             rsp_remainder,
    output logic [1:0]                     rsp_err,
    output logic                           div_start,
    output logic [P_WIDTH-1:0]             div_dividend,
    output logic [P_WIDTH-1:0]             div_divisor,
    input  logic [P_WIDTH-1:0]             div_quotient,
    input  logic [P_WIDTH-1:0]             div_remainder,
    input  logic                           div_done
);

    localparam int IW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
    localparam int CW = $clog2(P_TIMEOUT + 1);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state, state_d;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      win;
    logic [IW-1:0]      pick;
    logic               any_req;
    logic [P_WIDTH-1:0] op_a, op_b;
    logic [P_WIDTH-1:0] sel_a, sel_b;
    logic [P_WIDTH-1:0] res_q, res_r;
    logic [1:0]         res_err;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_inc;
    logic               tmo_hit;

    // First asserted index at or after the pointer, wrapping around.
    function automatic logic [IW-1:0] rr_pick(
        input logic [P_NUM_REQ-1:0] v,
        input logic [IW-1:0]        p
    );
        logic          found;
        logic [IW-1:0] r;
        int            j;
        found = 1'b0;
        r     = '0;
        for (int k = 0; k < P_NUM_REQ; k++) begin
            j = (int'(p) + k) % P_NUM_REQ;
            if (!found && v[j]) begin
                found = 1'b1;
                r     = IW'(j);
            end
        end
        return r;
    endfunction

    assign any_req = |req_valid;
    assign pick    = rr_pick(req_valid, ptr);
    assign sel_a   = req_dividend[int'(pick)*P_WIDTH +: P_WIDTH];
    assign sel_b   = req_divisor[int'(pick)*P_WIDTH +: P_WIDTH];
    assign cnt_inc = cnt + 1'b1;
    assign tmo_hit = (cnt_inc == CW'(P_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        req_ready = '0;
        rsp_valid = '0;
        div_start = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (any_req) begin
                    req_ready[pick] = 1'b1;
                    state_d = (sel_b == '0) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                div_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (div_done || tmo_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[win] = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            win     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            res_q   <= '0;
            res_r   <= '0;
            res_err <= ERR_OK;
            cnt     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        win  <= pick;
                        op_a <= sel_a;
                        op_b <= sel_b;
                        if (sel_b == '0) begin
                            res_q   <= '1;
                            res_r   <= sel_a;
                            res_err <= ERR_DIV0;
                        end
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    if (div_done) begin
                        res_q   <= div_quotient;
                        res_r   <= div_remainder;
                        res_err <= ERR_OK;
                    end else begin
                        cnt <= cnt_inc;
                        if (tmo_hit) begin
                            res_q   <= '0;
                            res_r   <= '0;
                            res_err <= ERR_TMO;
                        end
                    end
                end
                S_RESP: begin
                    ptr <= (win == IW'(P_NUM_REQ - 1)) ? '0 : win + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign div_dividend  = op_a;
    assign div_divisor   = op_b;
    // Result bus is driven only while the response strobe is up.
    assign rsp_quotient  = (state == S_RESP) ? res_q : '0;
    assign rsp_remainder = (state == S_RESP) ? res_r : '0;
    assign rsp_err       = (state == S_RESP) ? res_err : 2'b00;

endmodule

// File: tb/tb_div_32_arbiter.sv
// Directed bench for div_32_arbiter with a small fixed-latency divider model.
// Expected quotients, remainders and cycle offsets are hand-computed constants.
module tb_div_32_arbiter;

    localparam int W = 32;
    localparam int N = 4;
    localparam int T = 256;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_dividend = '0;
    logic [N*W-1:0] req_divisor = '0;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_quotient;
    logic [W-1:0]   rsp_remainder;
    logic [1:0]     rsp_err;
    logic           div_start;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic [W-1:0]   div_quotient;
    logic [W-1:0]   div_remainder;
    logic           div_done;

    div_32_arbiter #(.P_WIDTH(W), .P_NUM_REQ(N), .P_TIMEOUT(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_quotient (rsp_quotient),
        .rsp_remainder(rsp_remainder),
        .rsp_err      (rsp_err),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_done     (div_done)
    );

    always #5 clk = ~clk;

    // Divider model: done three cycles after the start pulse.
    logic [2:0]   dm_cnt;
    logic [W-1:0] dm_q, dm_r;
    logic         suppress = 1'b0;
    logic         late_done = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_cnt <= '0;
            dm_q   <= '0;
            dm_r   <= '0;
        end else if (div_start) begin
            dm_cnt <= 3'd3;
            dm_q   <= (div_divisor == 0) ? '1 : div_dividend / div_divisor;
            dm_r   <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
        end else if (dm_cnt != 0) begin
            dm_cnt <= dm_cnt - 3'd1;
        end
    end

    assign div_done      = ((dm_cnt == 3'd1) && !suppress) || late_done;
    assign div_quotient  = dm_q;
    assign div_remainder = dm_r;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int acc_idx[$];
    int acc_cyc[$];
    int rsp_idx[$];
    int rsp_cyc[$];
    logic [W-1:0] rsp_q[$];
    logic [W-1:0] rsp_r[$];
    logic [1:0]   rsp_e[$];
    int n_start = 0;
    int viol = 0;
    int done_last = 0;
    int nz = 0;
    logic watch_zero = 1'b0;

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (req_ready != 0) begin
            acc_idx.push_back(oh2i(req_ready));
            acc_cyc.push_back(cyc);
        end
        if (rsp_valid != 0) begin
            rsp_idx.push_back(oh2i(rsp_valid));
            rsp_cyc.push_back(cyc);
            rsp_q.push_back(rsp_quotient);
            rsp_r.push_back(rsp_remainder);
            rsp_e.push_back(rsp_err);
        end
        if (div_start) n_start = n_start + 1;
        if (div_done) done_last = cyc;
        if (req_ready != 0 && rsp_valid != 0) viol = viol + 1;
        if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) viol = viol + 1;
        if (watch_zero && (req_ready != 0 || rsp_valid != 0 || div_start ||
            rsp_quotient != 0 || rsp_remainder != 0 || rsp_err != 0 ||
            div_dividend != 0 || div_divisor != 0)) nz = nz + 1;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W]  = b;
        req_valid[i]           = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_acc(input string tag, input int target, input int budget);
        int b;
        b = budget;
        while (acc_idx.size() < target && b > 0) begin
            @(negedge clk);
            b--;
        end
        check({tag, "_acc_tmo"}, 64'(acc_idx.size() < target), 64'd0);
    endtask

    task automatic wait_rsp(input string tag, input int target, input int budget);
        int b;
        b = budget;
        while (rsp_idx.size() < target && b > 0) begin
            @(negedge clk);
            b--;
        end
        check({tag, "_rsp_tmo"}, 64'(rsp_idx.size() < target), 64'd0);
    endtask

    // Wait for the next accept and withdraw that requester after the grant edge.
    task automatic serve(input string tag);
        int a;
        a = acc_idx.size();
        wait_acc(tag, a + 1, 50);
        @(posedge clk);
        #1;
        if (acc_idx.size() > a) req_valid[acc_idx[a]] = 1'b0;
    endtask

    int ai, ri, s0, c0;
    int exp_q[5] = '{100, 50, 34, 25, 100};
    int exp_r[5] = '{0, 1, 0, 3, 0};

    initial begin
        // Reset and quiet idle
        do_reset();
        check("rst_outputs", {req_ready, rsp_valid, div_start, rsp_err,
              rsp_quotient, rsp_remainder != 0}, '0);
        watch_zero = 1'b1;
        tick(10);
        watch_zero = 1'b0;
        check("rst_idle_quiet", nz, 0);
        check("rst_no_accept", acc_idx.size(), 0);

        // Single request: requester 2, 200 / 7
        ai = acc_idx.size();
        ri = rsp_idx.size();
        s0 = n_start;
        set_req(2, 200, 7);
        c0 = cyc;
        serve("single");
        wait_rsp("single", ri + 1, 50);
        check("single_grant", acc_idx[ai], 2);
        check("single_acc_cycle", acc_cyc[ai], c0);
        check("single_rsp_idx", rsp_idx[ri], 2);
        check("single_q", rsp_q[ri], 28);
        check("single_r", rsp_r[ri], 4);
        check("single_err", rsp_e[ri], 0);
        check("single_start_cnt", n_start - s0, 1);
        check("single_rsp_after_done", rsp_cyc[ri] - done_last, 1);
        check("single_latency", rsp_cyc[ri] - acc_cyc[ai], 5);

        // Round-robin with all four requesters continuously valid
        do_reset();
        ai = acc_idx.size();
        ri = rsp_idx.size();
        for (int i = 0; i < N; i++) set_req(i, 100 + i, i + 1);
        wait_rsp("rr", ri + 5, 100);
        tick(1);
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_grant%0d", k), acc_idx[ai+k], k % N);
            check($sformatf("rr_rsp_idx%0d", k), rsp_idx[ri+k], k % N);
            check($sformatf("rr_q%0d", k), rsp_q[ri+k], exp_q[k]);
            check($sformatf("rr_r%0d", k), rsp_r[ri+k], exp_r[k]);
        end
        tick(3);

        // Divide by zero: requester 1, 55 / 0
        do_reset();
        ai = acc_idx.size();
        ri = rsp_idx.size();
        s0 = n_start;
        set_req(1, 55, 0);
        serve("dz");
        wait_rsp("dz", ri + 1, 20);
        tick(3);
        check("dz_rsp_idx", rsp_idx[ri], 1);
        check("dz_q", rsp_q[ri], 32'hFFFF_FFFF);
        check("dz_r", rsp_r[ri], 55);
        check("dz_err", rsp_e[ri], 1);
        check("dz_latency", rsp_cyc[ri] - acc_cyc[ai], 1);
        check("dz_no_start", n_start - s0, 0);

        // Timeout, then a normal request
        suppress = 1'b1;
        ai = acc_idx.size();
        ri = rsp_idx.size();
        set_req(0, 1000, 10);
        serve("tmo");
        wait_rsp("tmo", ri + 1, T + 50);
        check("tmo_err", rsp_e[ri], 2);
        check("tmo_q", rsp_q[ri], 0);
        check("tmo_r", rsp_r[ri], 0);
        check("tmo_latency", rsp_cyc[ri] - acc_cyc[ai], T + 2);
        suppress = 1'b0;
        tick(1);
        set_req(1, 9, 3);
        serve("post_tmo");
        wait_rsp("post_tmo", ri + 2, 50);
        check("post_tmo_q", rsp_q[ri+1], 3);
        check("post_tmo_r", rsp_r[ri+1], 0);
        check("post_tmo_err", rsp_e[ri+1], 0);

        // Reset while waiting on the divider
        do_reset();
        ri = rsp_idx.size();
        set_req(2, 50, 5);
        serve("mid_pre");
        wait_rsp("mid_pre", ri + 1, 50);
        tick(1);
        set_req(3, 40, 6);
        serve("mid_wait");
        tick(1);
        ri = rsp_idx.size();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        late_done = 1'b1;
        tick(1);
        late_done = 1'b0;
        tick(3);
        check("mid_no_rsp", rsp_idx.size() - ri, 0);
        ai = acc_idx.size();
        set_req(1, 21, 4);
        set_req(3, 40, 6);
        serve("mid_a");
        serve("mid_b");
        wait_rsp("mid", ri + 2, 50);
        check("mid_ptr_reset_grant", acc_idx[ai], 1);
        check("mid_second_grant", acc_idx[ai+1], 3);
        check("mid_q1", rsp_q[ri], 5);
        check("mid_r1", rsp_r[ri], 1);
        check("mid_rsp_idx3", rsp_idx[ri+1], 3);
        check("mid_q3", rsp_q[ri+1], 6);
        check("mid_r3", rsp_r[ri+1], 4);
        check("mid_err3", rsp_e[ri+1], 0);

        check("onehot_no_overlap", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
